apb_master_bridge: RTL and testbench

//  Single-outstanding APB3 initiator. Converts a simple req/gnt + rvalid core-side

---
 rtl/apb_master_bridge_if.sv | 38 +++
 rtl/apb_master_bridge.sv | 122 ++++++++++++
 tb/tb_apb_master_bridge.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// Signal bundle between the core-side request port and the APB3 peripheral bus.
// The master modport is the bridge's view; the slave modport is the core plus peripheral side.
interface apb_master_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_i;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  gnt_o;
    logic                  rvalid_o;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  err_o;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  req_i, we_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output req_i, we_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 initiator: core req/gnt/rvalid port to APB SETUP/ACCESS transfers.
// Optional ACCESS-phase timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_master_bridge_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                state;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;
    logic                  err_q;
    logic                  gnt;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
    end

    assign gnt = (state == IDLE) && bus.req_i;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] tmo_next;
    logic             tmo_hit;

    // Abort on the stall cycle whose increment brings the count to TIMEOUT_CYCLES.
    assign tmo_next = tmo_cnt + 1'b1;
    assign tmo_hit  = (tmo_next == CNT_W'(TIMEOUT_CYCLES));
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt) begin
                        pwrite_q  <= bus.we_i;
                        paddr_q   <= {bus.addr_i[ADDR_WIDTH-1:2], 2'b00};
                        pwdata_q  <= bus.wdata_i;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state     <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    tmo_cnt   <= '0;
`endif
                end
                ACCESS: begin
                    if (bus.PREADY) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        rdata_q   <= pwrite_q ? '0 : bus.PRDATA;
                        err_q     <= bus.PSLVERR;
                        rvalid_q  <= 1'b1;
                        state     <= IDLE;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (tmo_hit) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        rvalid_q  <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt   <= tmo_next;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt_o    = gnt;
    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = rdata_q;
    assign bus.err_o    = err_q;
    assign bus.PSEL     = psel_q;
    assign bus.PENABLE  = penable_q;
    assign bus.PWRITE   = pwrite_q;
    assign bus.PADDR    = paddr_q;
    assign bus.PWDATA   = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: inputs driven and outputs sampled on the falling edge.
module tb_apb_master_bridge;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          echo;
    logic [DW-1:0] prdata_drv;
    int            n_cmp = 0;
    int            n_bad = 0;

    apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master_bridge #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (bus.master)
    );

    always #5 PCLK = ~PCLK;

    // Slave read data: either a fixed value or an echo of the address for ordering checks.
    always_comb bus.PRDATA = echo ? {16'hC0DE, bus.PADDR[15:0]} : prdata_drv;

    task automatic test_reset;
        PRESET = 1'b1;
        repeat (3) @(negedge PCLK);
        n_cmp++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rvalid_o, bus.err_o, bus.gnt_o} !== 6'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b expected 000000",
                {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rvalid_o, bus.err_o, bus.gnt_o});
        end
        n_cmp++;
        if ({bus.PADDR, bus.PWDATA, bus.rdata_o} !== 96'h0) begin
            n_bad++; $display("FAIL reset_data: got %h expected 0", {bus.PADDR, bus.PWDATA, bus.rdata_o});
        end
        PRESET = 1'b0;
        @(negedge PCLK);
    endtask

    task automatic test_write;
        bus.PREADY = 1'b1; bus.PSLVERR = 1'b0; echo = 1'b0; prdata_drv = 32'hDEAD_BEEF;
        bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h4; bus.wdata_i = 32'hA5;
        #1;
        n_cmp++;
        if (bus.gnt_o !== 1'b1) begin n_bad++; $display("FAIL wr_gnt: got %b expected 1", bus.gnt_o); end
        @(negedge PCLK); #1;
        n_cmp++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.gnt_o} !== 4'b1010) begin
            n_bad++; $display("FAIL wr_setup: got %b expected 1010", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.gnt_o});
        end
        n_cmp++;
        if ({bus.PADDR, bus.PWDATA} !== {32'h4, 32'hA5}) begin
            n_bad++; $display("FAIL wr_setup_data: got %h expected %h", {bus.PADDR, bus.PWDATA}, {32'h4, 32'hA5});
        end
        bus.req_i = 1'b0; bus.addr_i = 32'hFC; bus.wdata_i = 32'hFFFF;
        @(negedge PCLK);
        n_cmp++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rvalid_o} !== 4'b1110) begin
            n_bad++; $display("FAIL wr_access: got %b expected 1110", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rvalid_o});
        end
        n_cmp++;
        if ({bus.PADDR, bus.PWDATA} !== {32'h4, 32'hA5}) begin
            n_bad++; $display("FAIL wr_access_hold: got %h expected %h", {bus.PADDR, bus.PWDATA}, {32'h4, 32'hA5});
        end
        @(negedge PCLK);
        n_cmp++;
        if ({bus.rvalid_o, bus.err_o, bus.PSEL, bus.PENABLE} !== 4'b1000) begin
            n_bad++; $display("FAIL wr_resp: got %b expected 1000", {bus.rvalid_o, bus.err_o, bus.PSEL, bus.PENABLE});
        end
        n_cmp++;
        if ({bus.rdata_o, bus.PADDR} !== {32'h0, 32'h4}) begin
            n_bad++; $display("FAIL wr_resp_data: got %h expected %h", {bus.rdata_o, bus.PADDR}, {32'h0, 32'h4});
        end
        @(negedge PCLK);
        n_cmp++;
        if (bus.rvalid_o !== 1'b0) begin n_bad++; $display("FAIL wr_pulse: got %b expected 0", bus.rvalid_o); end
    endtask

    task automatic test_read_wait;
        bus.PREADY = 1'b0; bus.PSLVERR = 1'b1; prdata_drv = 32'h1234_5678;
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h2; bus.wdata_i = 32'h0;
        #1;
        n_cmp++;
        if (bus.gnt_o !== 1'b1) begin n_bad++; $display("FAIL rd_gnt: got %b expected 1", bus.gnt_o); end
        @(negedge PCLK);
        bus.req_i = 1'b0;
        n_cmp++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR} !== {3'b100, 32'h0}) begin
            n_bad++; $display("FAIL rd_setup: got %h expected %h", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR}, {3'b100, 32'h0});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            n_cmp++;
            if ({bus.PSEL, bus.PENABLE, bus.rvalid_o, bus.PADDR} !== {3'b110, 32'h0}) begin
                n_bad++; $display("FAIL rd_access%0d: got %h expected %h", i,
                    {bus.PSEL, bus.PENABLE, bus.rvalid_o, bus.PADDR}, {3'b110, 32'h0});
            end
            if (i == 3) begin
                bus.PREADY = 1'b1; bus.PSLVERR = 1'b0; prdata_drv = 32'h0000_00FF;
            end
        end
        @(negedge PCLK);
        prdata_drv = 32'h1234_5678;
        n_cmp++;
        if ({bus.rvalid_o, bus.err_o, bus.PENABLE, bus.rdata_o} !== {3'b100, 32'hFF}) begin
            n_bad++; $display("FAIL rd_resp: got %h expected %h", {bus.rvalid_o, bus.err_o, bus.PENABLE, bus.rdata_o}, {3'b100, 32'hFF});
        end
        @(negedge PCLK);
        n_cmp++;
        if ({bus.rvalid_o, bus.rdata_o} !== {1'b0, 32'hFF}) begin
            n_bad++; $display("FAIL rd_hold: got %h expected %h", {bus.rvalid_o, bus.rdata_o}, {1'b0, 32'hFF});
        end
    endtask

    task automatic test_back_to_back;
        logic          exp_gnt;
        logic          exp_sel;
        logic          exp_rv;
        logic [31:0]   exp_addr;
        logic [31:0]   exp_rdata;
        bus.PREADY = 1'b1; bus.PSLVERR = 1'b0; echo = 1'b1; bus.we_i = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            bus.req_i  = (c < 12);
            bus.addr_i = 32'h100 + 32'(4 * (c / 3));
            #1;
            exp_gnt  = (c < 12) && (c % 3 == 0);
            exp_sel  = (c % 3 != 0);
            exp_rv   = (c > 0) && (c % 3 == 0);
            n_cmp++;
            if ({bus.gnt_o, bus.PSEL, bus.rvalid_o} !== {exp_gnt, exp_sel, exp_rv}) begin
                n_bad++; $display("FAIL b2b_ctrl c%0d: got %b expected %b", c,
                    {bus.gnt_o, bus.PSEL, bus.rvalid_o}, {exp_gnt, exp_sel, exp_rv});
            end
            if (c % 3 == 2) begin
                exp_addr = 32'h100 + 32'(4 * (c / 3));
                n_cmp++;
                if (bus.PADDR !== exp_addr) begin
                    n_bad++; $display("FAIL b2b_addr c%0d: got %h expected %h", c, bus.PADDR, exp_addr);
                end
            end
            if (exp_rv) begin
                exp_rdata = {16'hC0DE, 16'h0100 + 16'(4 * (c / 3 - 1))};
                n_cmp++;
                if (bus.rdata_o !== exp_rdata) begin
                    n_bad++; $display("FAIL b2b_rdata c%0d: got %h expected %h", c, bus.rdata_o, exp_rdata);
                end
            end
            @(negedge PCLK);
        end
        echo = 1'b0;
    endtask

`ifdef APB_MASTER_TIMEOUT_EN
    task automatic test_timeout;
        int hi;
        bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; prdata_drv = 32'h99;
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h40;
        @(negedge PCLK);
        bus.req_i = 1'b0;
        hi = 0;
        for (int i = 0; i < 40 && !bus.rvalid_o; i++) begin
            @(negedge PCLK);
            if (bus.PENABLE) hi++;
        end
        n_cmp++;
        if ({bus.rvalid_o, bus.err_o, bus.PSEL, bus.PENABLE} !== 4'b1100) begin
            n_bad++; $display("FAIL tmo_abort: got %b expected 1100", {bus.rvalid_o, bus.err_o, bus.PSEL, bus.PENABLE});
        end
        n_cmp++;
        if (hi !== 8) begin n_bad++; $display("FAIL tmo_cycles: got %0d expected 8", hi); end
        n_cmp++;
        if (bus.rdata_o !== 32'h0) begin n_bad++; $display("FAIL tmo_rdata: got %h expected 0", bus.rdata_o); end
        prdata_drv = 32'h77;
        bus.req_i = 1'b1;
        @(negedge PCLK);
        bus.req_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge PCLK);
            if (i == 7) bus.PREADY = 1'b1;
        end
        @(negedge PCLK);
        n_cmp++;
        if ({bus.rvalid_o, bus.err_o, bus.rdata_o} !== {2'b10, 32'h77}) begin
            n_bad++; $display("FAIL tmo_ready_wins: got %h expected %h", {bus.rvalid_o, bus.err_o, bus.rdata_o}, {2'b10, 32'h77});
        end
        @(negedge PCLK);
    endtask
`else
    task automatic test_stall;
        int stuck;
        bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; prdata_drv = 32'h99;
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h40;
        @(negedge PCLK);
        bus.req_i = 1'b0;
        stuck = 0;
        repeat (30) begin
            @(negedge PCLK);
            if (bus.PSEL && bus.PENABLE && !bus.rvalid_o) stuck++;
        end
        n_cmp++;
        if (stuck !== 30) begin n_bad++; $display("FAIL stall_hold: got %0d expected 30", stuck); end
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0; bus.PREADY = 1'b1;
        @(negedge PCLK);
    endtask
`endif

    task automatic test_slverr;
        bus.PREADY = 1'b1; bus.PSLVERR = 1'b1;
        bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h10; bus.wdata_i = 32'h3C;
        #1;
        n_cmp++;
        if (bus.gnt_o !== 1'b1) begin n_bad++; $display("FAIL err_gnt: got %b expected 1", bus.gnt_o); end
        @(negedge PCLK);
        bus.req_i = 1'b0;
        @(negedge PCLK);
        n_cmp++;
        if ({bus.PENABLE, bus.PADDR} !== {1'b1, 32'h10}) begin
            n_bad++; $display("FAIL err_access: got %h expected %h", {bus.PENABLE, bus.PADDR}, {1'b1, 32'h10});
        end
        @(negedge PCLK);
        n_cmp++;
        if ({bus.rvalid_o, bus.err_o, bus.rdata_o} !== {2'b11, 32'h0}) begin
            n_bad++; $display("FAIL err_resp: got %h expected %h", {bus.rvalid_o, bus.err_o, bus.rdata_o}, {2'b11, 32'h0});
        end
        @(negedge PCLK);
        n_cmp++;
        if ({bus.rvalid_o, bus.err_o} !== 2'b00) begin
            n_bad++; $display("FAIL err_pulse: got %b expected 00", {bus.rvalid_o, bus.err_o});
        end
        bus.PSLVERR = 1'b0;
    endtask

    task automatic test_reset_mid;
        int seen;
        bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; prdata_drv = 32'h55;
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h80;
        @(negedge PCLK);
        bus.req_i = 1'b0;
        @(negedge PCLK);
        n_cmp++;
        if ({bus.PSEL, bus.PENABLE} !== 2'b11) begin
            n_bad++; $display("FAIL rm_access: got %b expected 11", {bus.PSEL, bus.PENABLE});
        end
        PRESET = 1'b1; bus.PREADY = 1'b1;
        @(negedge PCLK);
        n_cmp++;
        if ({bus.PSEL, bus.PENABLE, bus.rvalid_o, bus.PADDR} !== {3'b000, 32'h0}) begin
            n_bad++; $display("FAIL rm_abort: got %h expected 0", {bus.PSEL, bus.PENABLE, bus.rvalid_o, bus.PADDR});
        end
        PRESET = 1'b0;
        seen = 0;
        repeat (3) begin
            @(negedge PCLK);
            if (bus.rvalid_o) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL rm_no_rvalid: got %0d expected 0", seen); end
        bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h20; bus.wdata_i = 32'h5A;
        #1;
        n_cmp++;
        if (bus.gnt_o !== 1'b1) begin n_bad++; $display("FAIL rm_gnt: got %b expected 1", bus.gnt_o); end
        @(negedge PCLK);
        bus.req_i = 1'b0;
        n_cmp++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA} !== {3'b101, 32'h20, 32'h5A}) begin
            n_bad++; $display("FAIL rm_setup: got %h expected %h",
                {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}, {3'b101, 32'h20, 32'h5A});
        end
        @(negedge PCLK);
        @(negedge PCLK);
        n_cmp++;
        if ({bus.rvalid_o, bus.err_o} !== 2'b10) begin
            n_bad++; $display("FAIL rm_resp: got %b expected 10", {bus.rvalid_o, bus.err_o});
        end
    endtask

    initial begin
        PRESET = 1'b1; echo = 1'b0; prdata_drv = '0;
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;
        bus.PREADY = 1'b1; bus.PSLVERR = 1'b0;
        test_reset();
        test_write();
        test_read_wait();
        test_back_to_back();
`ifdef APB_MASTER_TIMEOUT_EN
        test_timeout();
`else
        test_stall();
`endif
        test_slverr();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end
endmodule
